fetch_unit: RTL

Instruction-fetch stage of the 16-bit pipelined CPU, directly upstream of the decode/control stage. It owns the program counter, issues one-at-a-time requests to instruction memory, and loads the IF/ID pipeline register consumed by `control`. It honours the decode stage's `if_flush`/`pc_src` redirect and the hazard unit's stall, and it stops fetching on a HALT opcode (4'b1111).

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single outstanding imem requests,
// and loads the IF/ID register, honouring stall, flush/redirect and HALT.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        if_flush,
    input  logic        pc_src,
    input  logic [15:0] branch_target,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_buf;
    logic        r_drop;

    logic        w_redirect;
    logic [15:0] w_pc_inc;
    logic        w_rdata_halt;
    logic        w_buf_halt;
    logic        w_new;
    logic [15:0] w_new_instr;
    logic [15:0] w_new_pc;

    assign w_redirect   = if_flush & pc_src;
    assign w_pc_inc     = r_pc + 16'd2;
    assign w_rdata_halt = (imem_rdata[15:12] == 4'hF);
    assign w_buf_halt   = (r_buf[15:12] == 4'hF);

    // A word reaches IF/ID either straight from memory or from the hold buffer;
    // the IF/ID priority chain below filters it by flush and stall.
    assign w_new       = ((r_state == S_WAIT) & imem_valid & ~r_drop & ~w_redirect)
                       | (r_state == S_HOLD);
    assign w_new_instr = (r_state == S_HOLD) ? r_buf : imem_rdata;
    assign w_new_pc    = (r_state == S_HOLD) ? r_pc  : w_pc_inc;

    assign imem_req  = rst_n & (r_state == S_REQ) & ~w_redirect & ~halted;
    assign imem_addr = r_pc;

    // Fetch sequencer plus IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_buf       <= 16'h0000;
            r_drop      <= 1'b0;
            halted      <= 1'b0;
            if_id_instr <= 16'h0000;
            if_id_pc    <= 16'h0000;
            if_id_valid <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_redirect) begin
                        r_pc <= branch_target;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        if (r_drop || w_redirect) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                            if (w_redirect) begin
                                r_pc <= branch_target;
                            end
                        end else if (stall) begin
                            r_buf   <= imem_rdata;
                            r_pc    <= w_pc_inc;
                            r_state <= S_HOLD;
                        end else begin
                            r_pc <= w_pc_inc;
                            // A flushed HALT word must not stop the fetch
                            if (w_rdata_halt && !if_flush) begin
                                r_state <= S_HALT;
                                halted  <= 1'b1;
                            end else begin
                                r_state <= S_REQ;
                            end
                        end
                    end else if (w_redirect) begin
                        r_pc   <= branch_target;
                        r_drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_redirect) begin
                        r_buf   <= 16'h0000;
                        r_pc    <= branch_target;
                        r_state <= S_REQ;
                    end else if (!stall) begin
                        if (w_buf_halt && !if_flush) begin
                            r_state <= S_HALT;
                            halted  <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase

            if (r_state == S_HALT) begin
                if_id_valid <= if_id_valid;
            end else if (if_flush) begin
                if_id_valid <= 1'b0;
            end else if (stall) begin
                if_id_valid <= if_id_valid;
            end else if (w_new) begin
                if_id_instr <= w_new_instr;
                if_id_pc    <= w_new_pc;
                if_id_valid <= 1'b1;
            end else begin
                if_id_valid <= 1'b0;
            end
        end
    end

endmodule
